vga_dst: RTL and testbench

Display scan timing generator for the 800x600 VGA path. It produces the sync pulses `hs` and `vs`, the active-area enables `hen` and `ven`, and a frame-boundary strobe. Its enables are the `hen`/`ven` inputs consumed by the game display-data processor, which downsamples the image to 200x150. It sits directly after the pixel clock source and ahead of all display-data logic.

---
 rtl/vga_timing_pkg.sv | 21 ++
 rtl/vga_dst_if.sv | 21 ++
 rtl/vga_axis_cnt.sv | 60 ++++++
 rtl/vga_dst.sv | 90 +++++++++
 tb/tb_vga_dst.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and region encoding for the VGA scan generator.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 56;
  localparam int H_SYNC_DEF   = 120;
  localparam int H_BP_DEF     = 64;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 37;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BP_DEF     = 23;

  localparam int HT = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int VT = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_W = 11;
  localparam int V_W = 10;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_t;

endpackage

// File: rtl/vga_dst_if.sv
// Scan-timing bundle from vga_dst to display-data logic; x/y exist only with VGA_DST_COORD_EN.
interface vga_dst_if;
  import vga_timing_pkg::*;

  logic hs;
  logic vs;
  logic hen;
  logic ven;
  logic frame_end;
`ifdef VGA_DST_COORD_EN
  logic [H_W-1:0] x;
  logic [V_W-1:0] y;

  modport master (output hs, vs, hen, ven, frame_end, x, y);
  modport slave  (input  hs, vs, hen, ven, frame_end, x, y);
`else
  modport master (output hs, vs, hen, ven, frame_end);
  modport slave  (input  hs, vs, hen, ven, frame_end);
`endif

endinterface

// File: rtl/vga_axis_cnt.sv
// One scan axis: a wrapping counter and its ACTIVE/FRONT/SYNC/BACK region FSM.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int W        = 11,
  parameter int L_ACTIVE = 800,
  parameter int L_FRONT  = 56,
  parameter int L_SYNC   = 120,
  parameter int L_BACK   = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output region_t      region
);

  localparam int TOTAL = L_ACTIVE + L_FRONT + L_SYNC + L_BACK;

  localparam logic [W-1:0] END_ACTIVE = W'(L_ACTIVE - 1);
  localparam logic [W-1:0] END_FRONT  = W'(L_ACTIVE + L_FRONT - 1);
  localparam logic [W-1:0] END_SYNC   = W'(L_ACTIVE + L_FRONT + L_SYNC - 1);
  localparam logic [W-1:0] END_BACK   = W'(TOTAL - 1);

  logic [W-1:0] cnt_next;
  region_t      region_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      region <= ACTIVE;
    end else begin
      cnt    <= cnt_next;
      region <= region_next;
    end
  end

  // NOTE: hold-by-default assignments first keep this block free of inferred latches.
  always_comb begin
    cnt_next    = cnt;
    region_next = region;
    if (en) begin
      cnt_next = (cnt == END_BACK) ? '0 : cnt + W'(1);
      unique case (region)
        ACTIVE: if (cnt == END_ACTIVE) region_next = FRONT;
        FRONT:  if (cnt == END_FRONT)  region_next = SYNC;
        SYNC:   if (cnt == END_SYNC)   region_next = BACK;
        BACK:   if (cnt == END_BACK)   region_next = ACTIVE;
        default:                       region_next = ACTIVE;
      endcase
    end
  end

  always_comb begin
    wrap = en && (cnt == END_BACK);
  end

endmodule

// File: rtl/vga_dst.sv
// 800x600 VGA scan timing generator: registered sync, enables and frame strobe.
// Optional x/y active-pixel coordinates are built when VGA_DST_COORD_EN is defined.
module vga_dst
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic       pclk,
  input  logic       rst,
  vga_dst_if.master  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [V_W-1:0] V_FE_LINE = V_W'(V_ACTIVE);

  if (H_TOTAL > 2048) begin : g_h_total_check
    $error("vga_dst: horizontal total %0d exceeds 11-bit counter", H_TOTAL);
  end
  if (V_TOTAL > 1024) begin : g_v_total_check
    $error("vga_dst: vertical total %0d exceeds 10-bit counter", V_TOTAL);
  end

  logic           run;
  logic [H_W-1:0] hcnt;
  logic [V_W-1:0] vcnt;
  logic           hwrap;
  logic           vwrap_unused;
  region_t        hreg;
  region_t        vreg;
  logic           hen_d;
  logic           ven_d;

  // The first edge after reset release only arms the scan, so (0,0) is held one cycle.
  always_ff @(posedge pclk) begin
    if (rst) run <= 1'b0;
    else     run <= 1'b1;
  end

  vga_axis_cnt #(
    .W(H_W), .L_ACTIVE(H_ACTIVE), .L_FRONT(H_FP), .L_SYNC(H_SYNC), .L_BACK(H_BP)
  ) u_h (
    .clk(pclk), .rst(rst), .en(run), .cnt(hcnt), .wrap(hwrap), .region(hreg)
  );

  vga_axis_cnt #(
    .W(V_W), .L_ACTIVE(V_ACTIVE), .L_FRONT(V_FP), .L_SYNC(V_SYNC), .L_BACK(V_BP)
  ) u_v (
    .clk(pclk), .rst(rst), .en(hwrap), .cnt(vcnt), .wrap(vwrap_unused), .region(vreg)
  );

  // hen is gated by the vertical region so it never toggles together with ven except at frame start.
  always_comb begin
    ven_d = (vreg == ACTIVE);
    hen_d = (hreg == ACTIVE) && ven_d;
  end

  always_ff @(posedge pclk) begin
    if (rst || !run) begin
      vid.hen       <= 1'b0;
      vid.ven       <= 1'b0;
      vid.hs        <= ~SYNC_POL;
      vid.vs        <= ~SYNC_POL;
      vid.frame_end <= 1'b0;
`ifdef VGA_DST_COORD_EN
      vid.x         <= '0;
      vid.y         <= '0;
`endif
    end else begin
      vid.hen       <= hen_d;
      vid.ven       <= ven_d;
      vid.hs        <= (hreg == SYNC) ^ ~SYNC_POL;
      vid.vs        <= (vreg == SYNC) ^ ~SYNC_POL;
      vid.frame_end <= (vcnt == V_FE_LINE) && (hcnt == '0);
`ifdef VGA_DST_COORD_EN
      vid.x         <= hen_d ? hcnt : '0;
      vid.y         <= ven_d ? vcnt : '0;
`endif
    end
  end

endmodule

// File: tb/tb_vga_dst.sv
// Directed bench for vga_dst using a shrunken raster (30 pclk x 20 lines) so whole frames fit in a short run.
module tb_vga_dst;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  always #5 pclk = ~pclk;

  vga_dst_if vid ();

  vga_dst #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(10), .V_FP(3), .V_SYNC(2), .V_BP(5),
    .SYNC_POL(1'b1)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .vid (vid)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int t      = 0;

  int c_hen, c_ven, c_hs, c_vs, c_fe, c_both;
  logic p_hen, p_ven;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    t++;
  endtask

  task automatic go_to(input int target);
    while (t < target) tick();
  endtask

  initial begin
    // Reset held for 5 edges; all outputs deasserted.
    rst = 1'b1;
    repeat (5) tick();
    check("rst_hen", vid.hen, 0);
    check("rst_ven", vid.ven, 0);
    check("rst_hs",  vid.hs,  0);
    check("rst_vs",  vid.vs,  0);
    check("rst_fe",  vid.frame_end, 0);

    rst = 1'b0;
    tick();
    check("hold_hen", vid.hen, 0);
    check("hold_ven", vid.ven, 0);
    tick();
    t = 0;

    // Frame 0: t counts edges since the first active output (t = line*30 + pixel).
    check("start_hen", vid.hen, 1);
    check("start_ven", vid.ven, 1);
    check("start_hs",  vid.hs,  0);
`ifdef VGA_DST_COORD_EN
    check("x_first", vid.x, 0);
    check("y_first", vid.y, 0);
`endif
    go_to(15);  check("hen_last_px", vid.hen, 1);
`ifdef VGA_DST_COORD_EN
    check("x_last", vid.x, 15);
`endif
    go_to(16);  check("hen_fall", vid.hen, 0);
`ifdef VGA_DST_COORD_EN
    check("x_blank", vid.x, 0);
`endif
    go_to(19);  check("hs_before", vid.hs, 0);
    go_to(20);  check("hs_rise", vid.hs, 1);
    go_to(25);  check("hs_last", vid.hs, 1);
    go_to(26);  check("hs_fall", vid.hs, 0);
    go_to(30);  check("hen_line1", vid.hen, 1);
    go_to(285); check("hen_l9_last", vid.hen, 1);
    check("ven_l9", vid.ven, 1);
`ifdef VGA_DST_COORD_EN
    check("y_last_line", vid.y, 9);
    check("x_last_l9", vid.x, 15);
`endif
    go_to(286); check("hen_l9_fall", vid.hen, 0);
    check("ven_l9_hold", vid.ven, 1);
    go_to(299); check("ven_before_fall", vid.ven, 1);
    check("fe_before", vid.frame_end, 0);
    go_to(300); check("ven_fall", vid.ven, 0);
    check("hen_l10", vid.hen, 0);
    check("fe_pulse", vid.frame_end, 1);
`ifdef VGA_DST_COORD_EN
    check("y_blank", vid.y, 0);
`endif
    go_to(301); check("fe_clear", vid.frame_end, 0);
    go_to(389); check("vs_before", vid.vs, 0);
    go_to(390); check("vs_rise", vid.vs, 1);
    go_to(449); check("vs_last", vid.vs, 1);
    go_to(450); check("vs_fall", vid.vs, 0);
    go_to(599); check("hen_frame_end", vid.hen, 0);
    check("ven_frame_end", vid.ven, 0);
    go_to(600); check("hen_frame1", vid.hen, 1);
    check("ven_frame1", vid.ven, 1);

    // Frame 1: per-frame occupancy totals and edge-ordering rule.
    c_hen = 0; c_ven = 0; c_hs = 0; c_vs = 0; c_fe = 0; c_both = 0;
    p_hen = vid.hen; p_ven = vid.ven;
    for (int i = 0; i < 600; i++) begin
      if (i > 0 && (vid.hen !== p_hen) && (vid.ven !== p_ven)) c_both++;
      if (vid.hen === 1'b1) c_hen++;
      if (vid.ven === 1'b1) c_ven++;
      if (vid.hs === 1'b1) c_hs++;
      if (vid.vs === 1'b1) c_vs++;
      if (vid.frame_end === 1'b1) c_fe++;
      p_hen = vid.hen;
      p_ven = vid.ven;
      tick();
    end
    check("frame_hen_cycles", c_hen, 160);
    check("frame_ven_cycles", c_ven, 300);
    check("frame_hs_cycles",  c_hs,  120);
    check("frame_vs_cycles",  c_vs,  60);
    check("frame_fe_pulses",  c_fe,  1);
    check("hen_ven_same_edge", c_both, 0);
    check("hen_frame2", vid.hen, 1);
    check("ven_frame2", vid.ven, 1);

    // Mid-frame reset during hs on line 3 of frame 2.
    go_to(1312); check("hs_mid_line3", vid.hs, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_hs",  vid.hs,  0);
    check("mid_rst_hen", vid.hen, 0);
    check("mid_rst_ven", vid.ven, 0);
    rst = 1'b0;
    tick();
    check("mid_hold_hen", vid.hen, 0);
    tick();
    t = 0;
    check("restart_hen", vid.hen, 1);
    check("restart_ven", vid.ven, 1);
    check("restart_hs",  vid.hs,  0);
    go_to(20);  check("restart_hs_rise", vid.hs, 1);
    go_to(300); check("restart_fe", vid.frame_end, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
